// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types for the register-file responder:
// response codes and the write/read path state encodings.
package axi4_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic {W_COLLECT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA}    r_state_t;

endpackage

// File: rtl/axi4_lite_slave_regfile_if.sv
// AXI4-Lite bus bundle between a master and the register-file responder.
interface axi4_lite_slave_regfile_if
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  resp_t                 bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  resp_t                 rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite responder with NUM_REGS byte-strobed 32-bit registers; independent
// write and read paths, out-of-range accesses answered with SLVERR.
//
//  state     | meaning
//  W_COLLECT | accepting AW and W independently (aw_got/w_got); commits once both held
//  W_RESP    | BVALID asserted, BRESP held until BREADY
//  R_IDLE    | ARREADY asserted, waiting for ARVALID
//  R_DATA    | RVALID asserted, RDATA/RRESP held until RREADY
module axi4_lite_slave_regfile
  import axi4_lite_pkg::*;
#(
  parameter  int NUM_REGS   = 8,
  parameter  int ADDR_WIDTH = 32,
  localparam int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  axi4_lite_slave_regfile_if.slave  s_axi,
  output logic [NUM_REGS*32-1:0]    reg_q,
  output logic                      wr_pulse,
  output logic [IDX_W-1:0]          wr_index
);

  // Only word-index bits may be set (plus the ignored byte offset).
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (2 + IDX_W)) == '0;
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
    return a[2 +: IDX_W];
  endfunction

  w_state_t              w_state_q, w_state_d;
  logic                  aw_got_q, aw_got_d;
  logic                  w_got_q, w_got_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  resp_t                 bresp_q, bresp_d;
  logic                  wr_pulse_q, wr_pulse_d;
  logic [IDX_W-1:0]      wr_index_q, wr_index_d;
  logic [31:0]           regs_q [NUM_REGS];
  logic [31:0]           regs_d [NUM_REGS];

  r_state_t              r_state_q, r_state_d;
  logic [31:0]           rdata_q, rdata_d;
  resp_t                 rresp_q, rresp_d;

  assign s_axi.awready = (w_state_q == W_COLLECT) && !aw_got_q;
  assign s_axi.wready  = (w_state_q == W_COLLECT) && !w_got_q;
  assign s_axi.bvalid  = (w_state_q == W_RESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = (r_state_q == R_IDLE);
  assign s_axi.rvalid  = (r_state_q == R_DATA);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign wr_pulse      = wr_pulse_q;
  assign wr_index      = wr_index_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
    assign reg_q[32*g +: 32] = regs_q[g];
  end

  always_comb begin
    w_state_d  = w_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    wr_pulse_d = 1'b0;
    wr_index_d = wr_index_q;
    regs_d     = regs_q;
    case (w_state_q)
      W_COLLECT: begin
        if (aw_got_q && w_got_q) begin
          w_state_d = W_RESP;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          if (in_range(awaddr_q)) begin
            bresp_d    = RESP_OKAY;
            wr_pulse_d = 1'b1;
            wr_index_d = idx_of(awaddr_q);
            for (int b = 0; b < 4; b++) begin
              if (wstrb_q[b]) regs_d[idx_of(awaddr_q)][8*b +: 8] = wdata_q[8*b +: 8];
            end
          end else begin
            bresp_d = RESP_SLVERR;
          end
        end else begin
          if (s_axi.awvalid && !aw_got_q) begin
            aw_got_d = 1'b1;
            awaddr_d = s_axi.awaddr;
          end
          if (s_axi.wvalid && !w_got_q) begin
            w_got_d = 1'b1;
            wdata_d = s_axi.wdata;
            wstrb_d = s_axi.wstrb;
          end
        end
      end
      W_RESP: begin
        if (s_axi.bready) w_state_d = W_COLLECT;
      end
      default: w_state_d = W_COLLECT;
    endcase
  end

  // Read samples regs_q, so a read latched alongside a commit sees the old value.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi.arvalid) begin
          r_state_d = R_DATA;
          if (in_range(s_axi.araddr)) begin
            rdata_d = regs_q[idx_of(s_axi.araddr)];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end
      end
      R_DATA: begin
        if (s_axi.rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q  <= W_COLLECT;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= 1'b0;
      wr_index_q <= '0;
      regs_q     <= '{default: '0};
      r_state_q  <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      w_state_q  <= w_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      wr_index_q <= wr_index_d;
      regs_q     <= regs_d;
      r_state_q  <= r_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed bench for axi4_lite_slave_regfile with NUM_REGS=8.
module tb_axi4_lite_slave_regfile;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] reg_q;
  logic         wr_pulse;
  logic [2:0]   wr_index;

  int total = 0;
  int bad   = 0;

  axi4_lite_slave_regfile_if #(.ADDR_WIDTH(32)) bus ();

  axi4_lite_slave_regfile #(.NUM_REGS(8), .ADDR_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_axi    (bus),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse),
    .wr_index (wr_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] regv(input int i);
    return reg_q[32*i +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_start, input int w_start,
                          output logic [1:0] resp, output int pulses, output int lat,
                          output logic [2:0] idx);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    pulses = 0; lat = -1; idx = '0; resp = 2'bxx;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (cyc == aw_start) begin bus.awaddr = addr; bus.awvalid = 1'b1; end
      if (cyc == w_start) begin bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1; end
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      tick();
      cyc++;
      if (aw_hs) begin bus.awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin bus.wvalid  = 1'b0; w_done  = 1; end
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (wr_pulse) begin pulses++; idx = wr_index; end
      if (bus.bvalid) begin lat = n; break; end
      tick();
    end
    if (lat < 0) begin
      chk("b_timeout", {255'b0, bus.bvalid}, 256'd1);
      return;
    end
    resp = bus.bresp;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    if (wr_pulse) pulses++;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    bit ar_hs;
    lat = -1; data = 'x; resp = 2'bxx;
    bus.araddr = addr;
    bus.arvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      ar_hs = bus.arready;
      tick();
      if (ar_hs) break;
    end
    bus.arvalid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.rvalid) begin lat = n; break; end
      tick();
    end
    if (lat < 0) begin
      chk("r_timeout", {255'b0, bus.rvalid}, 256'd1);
      return;
    end
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  logic [1:0]  resp;
  logic [31:0] rd;
  logic [2:0]  idx;
  int          pulses, lat;

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    chk("rst_awready", bus.awready, 1);
    chk("rst_wready",  bus.wready,  1);
    chk("rst_arready", bus.arready, 1);
    chk("rst_bvalid",  bus.bvalid,  0);
    chk("rst_rvalid",  bus.rvalid,  0);
    chk("rst_pulse",   wr_pulse,    0);
    chk("rst_rdata",   bus.rdata,   0);
    chk("rst_regs",    reg_q,       0);

    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, resp, pulses, lat, idx);
    chk("w1_bresp",  resp,    2'b00);
    chk("w1_lat",    lat,     1);
    chk("w1_pulses", pulses,  1);
    chk("w1_index",  idx,     3'd1);
    chk("w1_reg1",   regv(1), 32'hDEADBEEF);
    do_read(32'h4, rd, resp, lat);
    chk("r1_data", rd,   32'hDEADBEEF);
    chk("r1_resp", resp, 2'b00);
    chk("r1_lat",  lat,  0);

    // Read of reg1 latched on the same edge its new value commits.
    bus.awaddr = 32'h4; bus.awvalid = 1'b1;
    bus.wdata = 32'h11111111; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 32'h4; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    chk("sim_rvalid", bus.rvalid, 1);
    chk("sim_rdata",  bus.rdata,  32'hDEADBEEF);
    chk("sim_bvalid", bus.bvalid, 1);
    chk("sim_pulse",  wr_pulse,   1);
    chk("sim_reg1",   regv(1),    32'h11111111);
    bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0; bus.rready = 1'b0;

    do_write(32'h8, 32'h12345678, 4'hF, 3, 0, resp, pulses, lat, idx);
    chk("wfirst_resp", resp,    2'b00);
    chk("wfirst_reg2", regv(2), 32'h12345678);
    do_write(32'h8, 32'h0, 4'hF, 0, 0, resp, pulses, lat, idx);
    chk("clr_reg2", regv(2), 32'h0);
    do_write(32'h8, 32'h12345678, 4'hF, 0, 3, resp, pulses, lat, idx);
    chk("awfirst_resp",  resp,    2'b00);
    chk("awfirst_index", idx,     3'd2);
    chk("awfirst_reg2",  regv(2), 32'h12345678);

    do_write(32'hC, 32'hFFFFFFFF, 4'hF, 0, 0, resp, pulses, lat, idx);
    do_write(32'hC, 32'h0, 4'b0101, 0, 0, resp, pulses, lat, idx);
    chk("strb_resp", resp,    2'b00);
    chk("strb_reg3", regv(3), 32'hFF00FF00);
    do_write(32'hC, 32'h12345678, 4'h0, 0, 0, resp, pulses, lat, idx);
    chk("strb0_resp",   resp,    2'b00);
    chk("strb0_pulses", pulses,  1);
    chk("strb0_reg3",   regv(3), 32'hFF00FF00);

    do_write(32'h100, 32'hCAFEF00D, 4'hF, 0, 0, resp, pulses, lat, idx);
    chk("oor_bresp",  resp,   2'b10);
    chk("oor_pulses", pulses, 0);
    chk("oor_regs",   reg_q,  {128'h0, 32'hFF00FF00, 32'h12345678, 32'h11111111, 32'h0});
    do_read(32'h100, rd, resp, lat);
    chk("oor_rresp", resp, 2'b10);
    chk("oor_rdata", rd,   32'h0);
    do_read(32'h5, rd, resp, lat);
    chk("lowbits_rdata", rd,   32'h11111111);
    chk("lowbits_rresp", resp, 2'b00);

    // Hold BREADY and RREADY low for five cycles each.
    bus.awaddr = 32'h10; bus.awvalid = 1'b1;
    bus.wdata = 32'hA5A55A5A; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bstall_bvalid",  bus.bvalid,  1);
      chk("bstall_bresp",   bus.bresp,   2'b00);
      chk("bstall_awready", bus.awready, 0);
      chk("bstall_wready",  bus.wready,  0);
      tick();
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("bstall_release", bus.awready, 1);
    bus.araddr = 32'h10; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rstall_rvalid",  bus.rvalid,  1);
      chk("rstall_rdata",   bus.rdata,   32'hA5A55A5A);
      chk("rstall_rresp",   bus.rresp,   2'b00);
      chk("rstall_arready", bus.arready, 0);
      tick();
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    chk("rstall_release", bus.arready, 1);

    // Reset while a write response is pending.
    bus.awaddr = 32'h14; bus.awvalid = 1'b1;
    bus.wdata = 32'h00000077; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    chk("mid_bvalid", bus.bvalid, 1);
    chk("mid_index",  wr_index,   3'd5);
    rst = 1'b1;
    #1;
    chk("mrst_bvalid", bus.bvalid, 0);
    chk("mrst_pulse",  wr_pulse,   0);
    chk("mrst_index",  wr_index,   0);
    chk("mrst_rdata",  bus.rdata,  0);
    chk("mrst_rresp",  bus.rresp,  0);
    chk("mrst_bresp",  bus.bresp,  0);
    chk("mrst_regs",   reg_q,      0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_awready", bus.awready, 1);
    chk("post_wready",  bus.wready,  1);
    chk("post_arready", bus.arready, 1);
    chk("post_bvalid",  bus.bvalid,  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
